// File: rtl/sync_monitor_array.sv
`default_nettype none
// ============================================================================
// sync_monitor_array : multi-channel input synchroniser with selectable depth,
//                      edge/runt activity counters and a request/valid read port.
// Optional macro SYNC_MON_CLR_ON_READ_EN : reading a counter also clears it.
// Revision : 1.0
// ============================================================================
module sync_monitor_array #(
  parameter int CHANNELS   = 4,
  parameter int MAX_STAGES = 4,
  parameter int CNT_W      = 8,
  parameter int SEL_W      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] async_in,
  input  logic [SEL_W-1:0]    stage_sel,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  input  logic                rd_req,
  input  logic [2:0]          rd_chan,
  input  logic                rd_sel,
  output logic                rd_valid,
  output logic [CNT_W-1:0]    rd_data
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SEL_W-1:0] eff_sel;
  logic [CNT_W-1:0] edge_cnt [CHANNELS];
  logic [CNT_W-1:0] runt_cnt [CHANNELS];
  logic [CNT_W-1:0] rd_mux;

  assign eff_sel = (stage_sel > MAX_SEL) ? MAX_SEL : stage_sel;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [MAX_STAGES-1:0] chain;
    logic                  tap;
    logic                  h1;
    logic                  h2;
    logic                  edge_inc;
    logic                  runt_inc;
    logic                  edge_clr;
    logic                  runt_clr;
    logic [CNT_W-1:0]      edge_q;
    logic [CNT_W-1:0]      runt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= '0;
      else     chain <= {chain[MAX_STAGES-2:0], async_in[c]};
    end

    // Tap is a plain mux off the chain flops; a depth change takes effect at once.
    always_comb begin
      tap = 1'b0;
      for (int i = 0; i < MAX_STAGES; i++)
        if (eff_sel == SEL_W'(i)) tap = chain[i];
    end

    assign sync_out[c]   = tap;
    assign rise_pulse[c] = tap & ~h1;
    assign fall_pulse[c] = ~tap & h1;
    assign edge_inc      = tap ^ h1;
    assign runt_inc      = edge_inc & (h1 ^ h2);

`ifdef SYNC_MON_CLR_ON_READ_EN
    assign edge_clr = rd_req & (rd_chan == 3'(c)) & ~rd_sel;
    assign runt_clr = rd_req & (rd_chan == 3'(c)) & rd_sel;
`else
    assign edge_clr = 1'b0;
    assign runt_clr = 1'b0;
`endif

    // A clear that coincides with an increment leaves the counter at 1.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        h1     <= 1'b0;
        h2     <= 1'b0;
        edge_q <= '0;
        runt_q <= '0;
      end else begin
        h1 <= tap;
        h2 <= h1;
        if (edge_clr)
          edge_q <= CNT_W'(edge_inc);
        else if (edge_inc && edge_q != CNT_MAX)
          edge_q <= edge_q + 1'b1;
        if (runt_clr)
          runt_q <= CNT_W'(runt_inc);
        else if (runt_inc && runt_q != CNT_MAX)
          runt_q <= runt_q + 1'b1;
      end
    end

    assign edge_cnt[c] = edge_q;
    assign runt_cnt[c] = runt_q;
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (rd_chan == 3'(c)) rd_mux = rd_sel ? runt_cnt[c] : edge_cnt[c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_monitor_array.sv
`default_nettype none
// tb_sync_monitor_array : directed + randomized checks against a sample-history model.
module tb_sync_monitor_array;
  localparam int CH  = 4;
  localparam int MS  = 4;
  localparam int CW  = 8;
  localparam int CMX = (1 << CW) - 1;
`ifdef SYNC_MON_CLR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] async_in = '0;
  logic [1:0]    stage_sel = '0;
  logic [CH-1:0] sync_out, rise_pulse, fall_pulse;
  logic          rd_req = 1'b0;
  logic [2:0]    rd_chan = '0;
  logic          rd_sel = 1'b0;
  logic          rd_valid;
  logic [CW-1:0] rd_data;

  always #5 clk = ~clk;

  sync_monitor_array #(.CHANNELS(CH), .MAX_STAGES(MS), .CNT_W(CW), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .stage_sel(stage_sel),
    .sync_out(sync_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .rd_req(rd_req), .rd_chan(rd_chan), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  int checks = 0;
  int errors = 0;

  // Model: sync_out is the input sample taken eff_sel edges ago.
  logic [CH-1:0] samp[$];
  logic [CH-1:0] m_h1, m_h2;
  int            edge_m[CH];
  int            runt_m[CH];
  logic          exp_valid;
  int            exp_data;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff();
    int s;
    s = int'(stage_sel);
    return (s >= MS) ? MS - 1 : s;
  endfunction

  function automatic logic [CH-1:0] m_sync();
    int idx;
    idx = samp.size() - 1 - eff();
    return (idx < 0) ? '0 : samp[idx];
  endfunction

  task automatic model_clear();
    samp.delete();
    m_h1 = '0;
    m_h2 = '0;
    for (int c = 0; c < CH; c++) begin
      edge_m[c] = 0;
      runt_m[c] = 0;
    end
    exp_valid = 1'b0;
    exp_data  = 0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] ps;
    int e, r, ch;
    bit hit;
    if (rst) begin
      model_clear();
      return;
    end
    ps = m_sync();
    ch = int'(rd_chan);
    exp_valid = rd_req;
    if (rd_req) exp_data = (ch < CH) ? (rd_sel ? runt_m[ch] : edge_m[ch]) : 0;
    for (int c = 0; c < CH; c++) begin
      e   = (ps[c] != m_h1[c]) ? 1 : 0;
      r   = (e == 1 && m_h1[c] != m_h2[c]) ? 1 : 0;
      hit = CLR && rd_req && (ch == c);
      if (hit && !rd_sel) edge_m[c] = e;
      else                edge_m[c] = (edge_m[c] + e > CMX) ? CMX : edge_m[c] + e;
      if (hit && rd_sel)  runt_m[c] = r;
      else                runt_m[c] = (runt_m[c] + r > CMX) ? CMX : runt_m[c] + r;
    end
    m_h2 = m_h1;
    m_h1 = ps;
    samp.push_back(async_in);
    if (samp.size() > 2 * MS) void'(samp.pop_front());
  endtask

  task automatic compare();
    logic [CH-1:0] s;
    s = m_sync();
    check("sync_out", int'(sync_out), int'(s));
    check("rise_pulse", int'(rise_pulse), int'(s & ~m_h1));
    check("fall_pulse", int'(fall_pulse), int'(~s & m_h1));
    check("rd_valid", int'(rd_valid), int'(exp_valid));
    if (exp_valid) check("rd_data", int'(rd_data), exp_data);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic do_read(input int ch, input bit sel, output int data);
    rd_req  = 1'b1;
    rd_chan = 3'(ch);
    rd_sel  = sel;
    step();
    data   = int'(rd_data);
    rd_req = 1'b0;
  endtask

  initial begin
    int d;
    model_clear();

    // Reset state
    repeat (3) step();
    check("reset_sync", int'(sync_out), 0);
    check("reset_valid", int'(rd_valid), 0);
    rst = 1'b0;

    // Latency for each depth
    for (int sel = 0; sel < 4; sel++) begin
      stage_sel = 2'(sel);
      async_in  = '0;
      repeat (6) step();
      async_in[0] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        step();
        check("lat_sync", int'(sync_out[0]), (k >= sel + 1) ? 1 : 0);
        check("lat_rise", int'(rise_pulse[0]), (k == sel + 1) ? 1 : 0);
      end
    end

    // Runt detection on channel 2
    stage_sel = 2'd1;
    repeat (6) step();
    async_in[2] = 1'b1; step();
    async_in[2] = 1'b0; repeat (6) step();
    do_read(2, 1'b0, d); check("runt_edge", d, 2);
    do_read(2, 1'b1, d); check("runt_runt", d, 1);
    async_in[2] = 1'b1; repeat (3) step();
    async_in[2] = 1'b0; repeat (6) step();
    do_read(2, 1'b0, d); check("long_edge", d, CLR ? 2 : 4);
    do_read(2, 1'b1, d); check("long_runt", d, CLR ? 0 : 1);

    // Saturation on channel 1
    for (int k = 0; k < 300; k++) begin
      async_in[1] = ~async_in[1];
      repeat (2) step();
    end
    repeat (6) step();
    do_read(1, 1'b1, d); check("sat_runt", d, 0);
    do_read(1, 1'b0, d); check("sat_edge", d, 255);

    // Back-to-back reads and out-of-range channel
    rd_req = 1'b1; rd_chan = 3'd3; rd_sel = 1'b0;
    step();
    check("b2b_valid0", int'(rd_valid), 1);
    check("b2b_data0", int'(rd_data), 0);
    rd_chan = 3'd0; rd_sel = 1'b1;
    step();
    check("b2b_valid1", int'(rd_valid), 1);
    check("b2b_data1", int'(rd_data), 0);
    rd_req = 1'b0; rd_chan = 3'd5;
    step();
    check("idle_valid", int'(rd_valid), 0);
    do_read(5, 1'b0, d);
    check("oor_valid", int'(rd_valid), 1);
    check("oor_data", d, 0);

    // Read behaviour: 7 edges, re-read, read coinciding with an edge
    for (int k = 0; k < 7; k++) begin
      async_in[3] = ~async_in[3];
      repeat (3) step();
    end
    repeat (6) step();
    do_read(3, 1'b0, d); check("cor_first", d, 7);
    do_read(3, 1'b0, d); check("cor_second", d, CLR ? 0 : 7);
    async_in[3] = ~async_in[3];
    step(); step();
    do_read(3, 1'b0, d); check("cor_coincide", d, CLR ? 0 : 7);
    repeat (4) step();
    do_read(3, 1'b0, d); check("cor_after", d, CLR ? 1 : 8);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) async_in = CH'($urandom);
      if ($urandom_range(0, 15) == 0) stage_sel = 2'($urandom);
      rd_req  = ($urandom_range(0, 2) == 0);
      rd_chan = 3'($urandom);
      rd_sel  = 1'($urandom);
      step();
    end

    // Asynchronous reset while a read is being returned
    async_in = 4'b1010;
    repeat (6) step();
    rd_req = 1'b1; rd_chan = 3'd1; rd_sel = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    check("arst_pre_valid", int'(rd_valid), int'(exp_valid));
    check("arst_pre_sync", int'(sync_out), int'(m_sync()));
    rd_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_clear();
    check("arst_valid", int'(rd_valid), 0);
    check("arst_sync", int'(sync_out), 0);
    check("arst_fall", int'(fall_pulse), 0);
    @(negedge clk);
    compare();
    async_in  = '0;
    stage_sel = 2'd0;
    step();
    rst = 1'b0;
    async_in[0] = 1'b1;
    step();
    check("post_rst_sync", int'(sync_out[0]), 1);
    check("post_rst_rise", int'(rise_pulse[0]), 1);
    repeat (2) step();
    do_read(1, 1'b0, d); check("post_rst_cnt1", d, 0);
    do_read(0, 1'b0, d); check("post_rst_cnt0", d, 1);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sync_monitor_array.md
Name: sync_monitor_array

Overview:
Parametrised multi-channel input synchroniser with a runtime-selectable stage depth and per-channel activity monitoring. Each channel passes an asynchronous input through a 1..MAX_STAGES flop chain and flags rising and falling edges. It counts edges and runt (single-cycle) pulses on the synchronised signal. The counters are read through a one-outstanding request/valid port. The block sits between the tile's raw input pins and the user logic.

Parameters:
CHANNELS, 4, number of independent input channels (1..8)
MAX_STAGES, 4, maximum synchroniser depth (2..8)
CNT_W, 8, width of each edge/runt counter
SEL_W, 2, width of stage_sel; must satisfy 2**SEL_W >= MAX_STAGES

Ports:
clk  input  1  single clock for all logic
rst  input  1  asynchronous, active-high reset; all state cleared while high
async_in  input  CHANNELS  raw asynchronous inputs
stage_sel  input  SEL_W  synchroniser depth minus one; values >= MAX_STAGES clamp to MAX_STAGES-1
sync_out  output  CHANNELS  synchronised inputs
rise_pulse  output  CHANNELS  one-cycle high on each rising edge of sync_out
fall_pulse  output  CHANNELS  one-cycle high on each falling edge of sync_out
rd_req  input  1  read request, sampled on posedge clk
rd_chan  input  3  channel to read; values >= CHANNELS return 0
rd_sel  input  1  0 = edge counter, 1 = runt counter
rd_valid  output  1  high exactly one cycle, the cycle after rd_req is sampled
rd_data  output  CNT_W  counter value, meaningful only while rd_valid is high

Behaviour:
- Reset: every chain flop, sync_out, the history regs, rise_pulse, fall_pulse, all counters, rd_valid and rd_data are 0.
- Per channel: chain s[0..MAX_STAGES-1]. s[0] <= async_in; s[i] <= s[i-1]. sync_out = s[eff_sel] with eff_sel = min(stage_sel, MAX_STAGES-1). This is a mux off flops and is not re-registered.
- Latency: a value stable at async_in before posedge 1 appears on sync_out after posedge eff_sel+1.
- History regs h1 <= sync_out and h2 <= h1.
  - rise_pulse = sync_out & ~h1.
  - fall_pulse = ~sync_out & h1.
  - Both are combinational from flops and are never high together.
- Edge counter: +1 on any cycle where rise_pulse or fall_pulse is high. Saturates at 2**CNT_W-1.
- Runt counter: +1 when h1 != sync_out and h2 != h1, i.e. sync_out held a value for exactly one cycle. Saturates the same way. A 0-1-0 sequence produces 2 edge counts and 1 runt count.
- stage_sel change mid-run: the new tap is used immediately. Any resulting transition on sync_out is a real edge for pulses and counters. No suppression is applied.
- Read port:
  - rd_req sampled at posedge N gives rd_valid=1 and rd_data = counter value at posedge N (pre-increment) during cycle N+1.
  - Back-to-back rd_req on consecutive cycles is legal; each gets its own valid cycle.
  - rd_valid is 0 whenever rd_req was 0 at the previous edge.
- rst asserted mid-read: rd_valid drops immediately (async) and the pending read is lost.

Optional Feature:
Macro: SYNC_MON_CLR_ON_READ_EN
- Defined: the counter addressed by an accepted rd_req is cleared at the same edge that captures rd_data. If the counter also increments on that edge, its new value is 1, not 0 and not old+1. An out-of-range rd_chan clears nothing.
- Undefined: reads are non-destructive and counters clear only on rst.

Test Plan:
1. Reset/latency: CHANNELS=4, MAX_STAGES=4, stage_sel=0..3, drive async_in[0] 0->1 before posedge 1 -> sync_out[0] rises after posedge 1/2/3/4 respectively; rise_pulse[0] high exactly 1 cycle; all outputs 0 during rst.
2. Runt detect: stage_sel=1, async_in[2] high for exactly 1 cycle then low -> edge counter ch2 = 2, runt counter ch2 = 1; a 3-cycle pulse -> edge +2, runt +0.
3. Saturation: CNT_W=8, toggle async_in[1] every 2 cycles for 300 toggles -> edge counter reads 255, no wrap to 0.
4. Read handshake: rd_req at posedge 10 (chan 3, sel 0) and 11 (chan 0, sel 1) -> rd_valid high cycles 11 and 12 with the correct values; rd_chan=5 -> rd_data=0, rd_valid=1.
5. Clear-on-read (macro defined): counter=7, read it -> rd_data=7, next read 0. Read coinciding with an edge -> next read 1. Macro undefined -> second read returns 7 (or 8 with the edge).
6. Async reset mid-operation: assert rst between clock edges while rd_valid=1 and counters non-zero -> rd_valid, sync_out and counters go 0 immediately, without waiting for a clock edge. Release -> normal latency restarts.
